// File: rtl/global_pkg.sv
// Shared UART receive types and constants.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package global_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO with registered read port; data appears 1 cycle after pop, full/empty from pointers.
// Writes while full and reads while empty are ignored; a pop never frees room for a same-cycle push.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_vld,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push_vld && !full;
  assign do_pop  = pop_vld && !empty;

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pop_dat <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) begin
        pop_dat <= mem[rd_ptr[AW-1:0]];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver into a byte FIFO; bytes visible 1 cycle after the stop sample, popped data 1 cycle after Data_Read.
// Full FIFO drops the byte with an Overrun pulse; UART_RX_PARITY_EN adds an even-parity bit before stop.
module uart_rx
  import global_pkg::*;
#(
  parameter int BAUD_DIV   = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       RX,
  output logic [7:0] RX_Data,
  output logic       RX_Full,
  output logic       RX_Empty,
  input  logic       Data_Read,
  output logic       Frame_Err,
  output logic       Overrun
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_rx_state_t state;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           rx_meta;
  logic           rx_sync;
  logic           rx_prev;
  logic           stop_ok;
  logic           push;

`ifdef UART_RX_PARITY_EN
  logic par_err;
  assign stop_ok = rx_sync && !par_err;
`else
  assign stop_ok = rx_sync;
`endif

  // Push decision uses the FIFO's current full flag, sampled in the stop-sample cycle.
  assign push = (state == STOP) && (cnt == '0) && stop_ok && !RX_Full;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      Frame_Err <= 1'b0;
      Overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      rx_meta   <= RX;
      rx_sync   <= rx_meta;
      rx_prev   <= rx_sync;
      Frame_Err <= 1'b0;
      Overrun   <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_prev && !rx_sync) begin
            cnt   <= HALF_LOAD;
            state <= START;
          end
        end
        START: begin
          if (cnt != '0) cnt <= cnt - CNT_ONE;
          else if (!rx_sync) begin
            cnt     <= FULL_LOAD;
            bit_idx <= '0;
            state   <= DATA;
          end else state <= IDLE;
        end
        DATA: begin
          if (cnt != '0) cnt <= cnt - CNT_ONE;
          else begin
            shift   <= {rx_sync, shift[7:1]};
            cnt     <= FULL_LOAD;
            bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == LAST_BIT) state <= PARITY;
`else
            if (bit_idx == LAST_BIT) state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt != '0) cnt <= cnt - CNT_ONE;
          else begin
            par_err <= ^{shift, rx_sync};
            cnt     <= FULL_LOAD;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (cnt != '0) cnt <= cnt - CNT_ONE;
          else begin
            if (!stop_ok) Frame_Err <= 1'b1;
            else if (RX_Full) Overrun <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk      (Clk),
    .Rst      (Rst),
    .push_vld (push),
    .push_dat (shift),
    .pop_vld  (Data_Read),
    .pop_dat  (RX_Data),
    .full     (RX_Full),
    .empty    (RX_Empty)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with BAUD_DIV=8, FIFO_DEPTH=4.
module tb_uart_rx;
  import global_pkg::*;

  localparam int BD = 8;
  localparam int FD = 4;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       RX = 1'b1;
  logic       Data_Read = 1'b0;
  logic [7:0] RX_Data;
  logic       RX_Full, RX_Empty, Frame_Err, Overrun;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  uart_rx #(.BAUD_DIV(BD), .FIFO_DEPTH(FD)) dut (
    .Clk(Clk), .Rst(Rst), .RX(RX), .RX_Data(RX_Data), .RX_Full(RX_Full),
    .RX_Empty(RX_Empty), .Data_Read(Data_Read), .Frame_Err(Frame_Err), .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Frame_Err) fe_cnt++;
    if (Overrun) ov_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    RX = 1'b0; tick(BD);
    for (int i = 0; i < 8; i++) begin
      RX = d[i]; tick(BD);
    end
`ifdef UART_RX_PARITY_EN
    RX = par; tick(BD);
`endif
    RX = stop; tick(BD);
    RX = 1'b1;
  endtask

  task automatic pop(output logic [7:0] d, output logic e);
    Data_Read = 1'b1;
    tick(1);
    Data_Read = 1'b0;
    d = RX_Data;
    e = RX_Empty;
  endtask

  task automatic test_reset();
    tick(3);
    checks++; if (RX_Empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", RX_Empty); end
    checks++; if (RX_Full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", RX_Full); end
    checks++; if (RX_Data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", RX_Data); end
    checks++; if (Frame_Err !== 1'b0 || Overrun !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b want 00", Frame_Err, Overrun); end
    Rst = 1'b0;
    tick(3);
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", dut.state); end
  endtask

  task automatic test_single();
    logic [7:0] d; logic e; int fe0;
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(2);
    checks++; if (RX_Empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b want 0", RX_Empty); end
    pop(d, e);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL single_data got %h want a5", d); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL single_empty_after got %b want 1", e); end
    pop(d, e);
    checks++; if (d !== 8'hA5 || e !== 1'b1) begin errors++; $display("FAIL read_when_empty got %h/%b want a5/1", d, e); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL single_no_frame_err got %0d want 0", fe_cnt - fe0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4];
    logic [7:0] d; logic e; int ov0, fe0;
    exp[0] = 8'h01; exp[1] = 8'h80; exp[2] = 8'hFF; exp[3] = 8'h00;
    fe0 = fe_cnt;
    for (int i = 0; i < 4; i++) send_frame(exp[i], 1'b1, ^exp[i]);
    tick(2);
    checks++; if (RX_Full !== 1'b1) begin errors++; $display("FAIL b2b_full got %b want 1", RX_Full); end
    ov0 = ov_cnt;
    send_frame(8'h3C, 1'b1, 1'b0);
    tick(2);
    checks++; if (ov_cnt - ov0 != 1) begin errors++; $display("FAIL overrun_pulses got %0d want 1", ov_cnt - ov0); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL b2b_frame_err got %0d want 0", fe_cnt - fe0); end
    for (int i = 0; i < 4; i++) begin
      pop(d, e);
      checks++; if (d !== exp[i]) begin errors++; $display("FAIL b2b_data%0d got %h want %h", i, d, exp[i]); end
      if (i == 0) begin
        checks++; if (RX_Full !== 1'b0) begin errors++; $display("FAIL b2b_full_after_pop got %b want 0", RX_Full); end
      end
    end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL b2b_empty_end got %b want 1", e); end
  endtask

  task automatic test_frame_err();
    logic [7:0] d; logic e; int fe0;
    fe0 = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    tick(2);
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL frame_err_pulses got %0d want 1", fe_cnt - fe0); end
    checks++; if (RX_Empty !== 1'b1) begin errors++; $display("FAIL frame_err_empty got %b want 1", RX_Empty); end
    send_frame(8'h66, 1'b1, 1'b0);
    tick(2);
    pop(d, e);
    checks++; if (d !== 8'h66 || e !== 1'b1) begin errors++; $display("FAIL after_frame_err got %h/%b want 66/1", d, e); end
  endtask

  task automatic test_glitch();
    int fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    RX = 1'b0; tick(2);
    RX = 1'b1; tick(20);
    checks++; if (fe_cnt != fe0 || ov_cnt != ov0) begin errors++; $display("FAIL glitch_flags got %0d/%0d want 0/0", fe_cnt - fe0, ov_cnt - ov0); end
    checks++; if (RX_Empty !== 1'b1) begin errors++; $display("FAIL glitch_empty got %b want 1", RX_Empty); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL glitch_state got %0d want IDLE", dut.state); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pd; logic [7:0] d; logic e;
    pd = 8'hC3;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(2);
    checks++; if (RX_Empty !== 1'b0) begin errors++; $display("FAIL mid_buffered_empty got %b want 0", RX_Empty); end
    RX = 1'b0; tick(BD);
    for (int i = 0; i < 4; i++) begin
      RX = pd[i]; tick(BD);
    end
    RX = pd[4]; tick(BD / 2);
    Rst = 1'b1; RX = 1'b1;
    tick(1);
    checks++; if (RX_Empty !== 1'b1 || RX_Full !== 1'b0) begin errors++; $display("FAIL mid_rst_flags got %b%b want 10", RX_Empty, RX_Full); end
    checks++; if (RX_Data !== 8'h00) begin errors++; $display("FAIL mid_rst_data got %h want 00", RX_Data); end
    checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL mid_rst_state got %0d want IDLE", dut.state); end
    Rst = 1'b0;
    tick(4);
    send_frame(8'h7E, 1'b1, 1'b0);
    tick(2);
    pop(d, e);
    checks++; if (d !== 8'h7E || e !== 1'b1) begin errors++; $display("FAIL mid_rst_next got %h/%b want 7e/1", d, e); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] d; logic e; int fe0;
    fe0 = fe_cnt;
    send_frame(8'h03, 1'b1, 1'b0);
    tick(2);
    pop(d, e);
    checks++; if (d !== 8'h03 || e !== 1'b1) begin errors++; $display("FAIL parity_ok got %h/%b want 03/1", d, e); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL parity_ok_flag got %0d want 0", fe_cnt - fe0); end
    send_frame(8'h03, 1'b1, 1'b1);
    tick(2);
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL parity_bad_flag got %0d want 1", fe_cnt - fe0); end
    checks++; if (RX_Empty !== 1'b1) begin errors++; $display("FAIL parity_bad_empty got %b want 1", RX_Empty); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
